// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler sharing one resource among NUM_PORTS requesters.
// A grant is held until done, request drop, or the hold budget expires; outputs are registered.
module rr_grant_scheduler #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_HOLD  = 8,
    parameter int ID_W      = $clog2(NUM_PORTS),
    parameter int CNT_W     = $clog2(MAX_HOLD + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] done_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 gnt_valid_o,
    output logic [ID_W-1:0]      gnt_id_o,
    output logic                 timeout_o
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic                 timeout_q, timeout_d;

    logic                 arb_found;
    logic [ID_W-1:0]      arb_sel;
    logic                 rel_done, rel_drop, rel_budget;
    logic [ID_W-1:0]      ptr_next;

    // Scan starting at ptr_q so the port after the last owner has top priority.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            int              slot;
            logic [ID_W-1:0] idx;
            slot = int'(ptr_q) + i;
            if (slot >= NUM_PORTS) slot = slot - NUM_PORTS;
            idx = ID_W'(slot);
            if (!arb_found && req_i[idx]) begin
                arb_found = 1'b1;
                arb_sel   = idx;
            end
        end
    end

    assign rel_done   = done_i[gnt_id_q];
    assign rel_drop   = !req_i[gnt_id_q];
    assign rel_budget = (cnt_q >= CNT_W'(MAX_HOLD));
    assign ptr_next   = (gnt_id_q == ID_W'(NUM_PORTS - 1)) ? '0 : gnt_id_q + ID_W'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        gnt_id_d  = '0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d         = GRANT;
                    gnt_d[arb_sel]  = 1'b1;
                    gnt_id_d        = arb_sel;
                    cnt_d           = CNT_W'(1);
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || rel_budget) begin
                    // Release forces one dead cycle; timeout only flags a pure budget expiry.
                    state_d   = IDLE;
                    cnt_d     = '0;
                    ptr_d     = ptr_next;
                    timeout_d = rel_budget && !rel_done && !rel_drop;
                end else begin
                    gnt_d    = gnt_q;
                    gnt_id_d = gnt_id_q;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = gnt_id_q;
    assign gnt_valid_o = (state_q == GRANT);
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scoreboard bench for rr_grant_scheduler: stimulus pushes expected outputs from a
// port-level reference model; an independent monitor pops and compares every cycle.
module tb_rr_grant_scheduler;

    localparam int N   = 4;
    localparam int MAX = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [N-1:0] req_i = '0;
    logic [N-1:0] done_i = '0;
    logic [N-1:0] gnt_o;
    logic         gnt_valid_o;
    logic [1:0]   gnt_id_o;
    logic         timeout_o;

    rr_grant_scheduler #(.NUM_PORTS(N), .MAX_HOLD(MAX)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .done_i      (done_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_id_o    (gnt_id_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    // Reference model: who owns the resource, whose turn is next, how long held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        logic [1:0] id;
        g  = '0;
        id = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            id = 2'(m_owner);
        end
        return {m_to, (m_owner >= 0), id, g};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] done);
        bit d, r, t;
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (m_owner < 0 && req[p]) begin
                    m_owner = p;
                    m_held  = 1;
                end
            end
        end else begin
            d = done[m_owner];
            r = !req[m_owner];
            t = (m_held == MAX);
            if (d || r || t) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_held  = 0;
                m_to    = t && !d && !r;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] req, input logic [N-1:0] done);
        @(negedge clk_i);
        req_i  = req;
        done_i = done;
        model_step(req, done);
        exp_q.push_back(model_out());
    endtask

    function automatic logic [N-1:0] owner_done(input int at_held);
        logic [N-1:0] v;
        v = '0;
        if (m_owner >= 0 && m_held == at_held) v[m_owner] = 1'b1;
        return v;
    endfunction

    task automatic wait_owner(input logic [N-1:0] req, input int port);
        for (int k = 0; k < 20 && m_owner != port; k++) step(req, '0);
        check("reach_owner", 32'(m_owner), 32'(port));
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {24'd0, timeout_o, gnt_valid_o, gnt_id_o, gnt_o}, 32'd0);
    endtask

    // Monitor: every cycle the DUT presents registered outputs, compare with the oldest expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", {24'd0, timeout_o, gnt_valid_o, gnt_id_o, gnt_o}, {24'd0, e});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] r, d;

        // T1: outputs stay zero under reset while inputs toggle.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            req_i  = 4'($urandom);
            done_i = 4'($urandom);
            @(posedge clk_i);
            #1;
            check_outputs_zero("reset_hold");
        end
        @(negedge clk_i);
        req_i  = '0;
        done_i = '0;
        rst_ni = 1'b1;
        model_reset();
        step(4'b1111, '0);

        // T2: rotation with done two cycles into each grant.
        for (int k = 0; k < 16; k++) step(4'b1111, owner_done(2));

        // T3: lone requester hits the hold budget, then is regranted.
        for (int k = 0; k < 3; k++) step(4'b0000, '0);
        for (int k = 0; k < 22; k++) step(4'b0100, '0);

        // T4: wrap from port 3 to port 0, skipping idle ports.
        wait_owner(4'b1000, 3);
        step(4'b1000, 4'b1000);
        for (int k = 0; k < 8; k++) step(4'b1001, owner_done(2));

        // T5: request drop releases early; a non-owner done is ignored.
        step(4'b0000, '0);
        wait_owner(4'b0010, 1);
        step(4'b0010, 4'b0100);
        step(4'b0010, 4'b0100);
        step(4'b0000, '0);
        step(4'b0000, '0);

        // T6: asynchronous reset in the middle of a grant.
        wait_owner(4'b0100, 2);
        step(4'b0100, '0);
        @(posedge clk_i);
        #3;
        check("pre_reset_gnt", {28'd0, gnt_o}, 32'b0100);
        rst_ni = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        model_reset();
        req_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(4'b1111, '0);
        step(4'b1111, '0);

        // Random traffic with sticky requests and noisy done pulses.
        r = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
            d = '0;
            for (int b = 0; b < N; b++) if ($urandom_range(3) == 0) d[b] = 1'b1;
            if (m_owner >= 0 && $urandom_range(5) != 0) d[m_owner] = 1'b0;
            step(r, d);
        end

        @(posedge clk_i);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
